bus_responder: RTL and testbench

Target side of the CPU memory bus. Accepts the single-outstanding start/done transactions the control unit issues for instruction fetch, READ, WRITE and COPY. Serves them from an internal word RAM and a small I/O register window, with a configurable number of wait states. Sits between the CPU bus port and on-chip memory. It replaces the ad-hoc memory model in CPU simulations and is the first real target for the bus.

---
 rtl/bus_responder.sv | 150 +++++++++++++++
 tb/tb_bus_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// Target side of the CPU start/done bus: serves a word RAM and a small
// ID/SCRATCH/CYCLES register window, with WAIT extra cycles per transaction.
module bus_responder #(
  parameter int          RAM_AW   = 10,
  parameter int          WAIT     = 0,
  parameter logic [31:0] ID_VALUE = 32'h46504735
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] bus_addr,
  input  logic [31:0] bus_data,
  input  logic        bus_we,
  input  logic        bus_start,
  output logic [31:0] bus_q,
  output logic        bus_done
);

  localparam logic [26:0] ADDR_ID      = 27'h7FFFFF0;
  localparam logic [26:0] ADDR_SCRATCH = 27'h7FFFFF1;
  localparam logic [26:0] ADDR_CYCLES  = 27'h7FFFFF2;
  localparam logic [3:0]  WAIT_CYC     = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_ID,
    SEL_SCRATCH,
    SEL_CYCLES,
    SEL_NONE
  } sel_t;

  state_t              state;
  state_t              next_state;
  logic [3:0]          wait_cnt;
  logic [26:0]         lat_addr;
  logic [31:0]         lat_data;
  logic                lat_we;
  logic                accept;
  logic                commit;
  sel_t                sel;
  logic [RAM_AW-1:0]   ram_idx;
  logic [31:0]         rd_val;
  logic [31:0]         scratch;
  logic [31:0]         cycles;
  logic                wr_ram;
  logic                wr_scratch;
  logic                wr_cycles;
  logic [31:0]         ram [2**RAM_AW];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus_start) begin
          accept     = 1'b1;
          next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (wait_cnt == 4'd0) begin
          commit     = 1'b1;
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_addr <= bus_addr;
        lat_data <= bus_data;
        lat_we   <= bus_we;
        wait_cnt <= WAIT_CYC;
      end else if (state == S_ACCESS && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Decode works on the latched address so mid-transaction bus changes are harmless.
  always_comb begin
    sel = SEL_NONE;
    if (lat_addr[26:RAM_AW] == '0)      sel = SEL_RAM;
    else if (lat_addr == ADDR_ID)       sel = SEL_ID;
    else if (lat_addr == ADDR_SCRATCH)  sel = SEL_SCRATCH;
    else if (lat_addr == ADDR_CYCLES)   sel = SEL_CYCLES;
  end

  assign ram_idx    = lat_addr[RAM_AW-1:0];
  assign wr_ram     = commit && lat_we && (sel == SEL_RAM);
  assign wr_scratch = commit && lat_we && (sel == SEL_SCRATCH);
  assign wr_cycles  = commit && lat_we && (sel == SEL_CYCLES);

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_RAM:     rd_val = ram[ram_idx];
      SEL_ID:      rd_val = ID_VALUE;
      SEL_SCRATCH: rd_val = scratch;
      SEL_CYCLES:  rd_val = cycles;
      default:     rd_val = '0;
    endcase
  end

  // NOTE: the RAM array has no reset so it can map onto memory macros; contents stay undefined until written.
  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= lat_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           scratch <= '0;
    else if (wr_scratch) scratch <= lat_data;
  end

  // A load on the commit edge overrides that edge's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cycles <= '0;
    else if (wr_cycles) cycles <= lat_data;
    else                cycles <= cycles + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  bus_q <= '0;
    else if (commit && !lat_we) bus_q <= rd_val;
  end

  assign bus_done = (state == S_DONE);

  a_done_single: assert property (@(posedge clk) disable iff (reset) bus_done |=> !bus_done);

endmodule

// File: tb/tb_bus_responder.sv
// Randomized self-checking bench for bus_responder: three instances (WAIT=0,2,3)
// compared every cycle against a timestamp-based transaction model.
`timescale 1ns/1ps
module tb_bus_responder;

  localparam int N = 3;
  localparam logic [26:0] A_ID  = 27'h7FFFFF0;
  localparam logic [26:0] A_SCR = 27'h7FFFFF1;
  localparam logic [26:0] A_CYC = 27'h7FFFFF2;
  localparam logic [31:0] ID_V  = 32'h46504735;

  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] addr  [N];
  logic [31:0] wdata [N];
  logic        we    [N];
  logic        start [N];
  logic [31:0] q     [N];
  logic        done  [N];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    bus_responder #(
      .RAM_AW  (10),
      .WAIT    ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
      .ID_VALUE(32'h46504735)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .bus_addr (addr[g]),
      .bus_data (wdata[g]),
      .bus_we   (we[g]),
      .bus_start(start[g]),
      .bus_q    (q[g]),
      .bus_done (done[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: each accepted request is a timestamp; commit and
  // done cycles follow from the accept edge, CYCLES is base + elapsed edges.
  typedef struct {
    int          commit_e;
    int          free_e;
    logic [26:0] a;
    logic [31:0] d;
    logic        w;
    logic [31:0] q;
    bit          q_known;
    logic [31:0] scratch;
    logic [31:0] cnt_base;
    int          cnt_edge;
  } mdl_t;

  mdl_t        m [N];
  logic [31:0] mram [int];
  int          e;

  function automatic logic [31:0] cnt_at(input int i, input int k);
    return m[i].cnt_base + 32'(k - m[i].cnt_edge);
  endfunction

  task automatic model_commit(input int i);
    int key;
    key = i * 4096 + int'(m[i].a[9:0]);
    if (m[i].w) begin
      if (m[i].a < 27'd1024)   mram[key] = m[i].d;
      else if (m[i].a == A_SCR) m[i].scratch = m[i].d;
      else if (m[i].a == A_CYC) begin
        m[i].cnt_base = m[i].d;
        m[i].cnt_edge = e;
      end
    end else begin
      m[i].q_known = 1'b1;
      if (m[i].a < 27'd1024) begin
        if (mram.exists(key)) m[i].q = mram[key];
        else                  m[i].q_known = 1'b0;
      end
      else if (m[i].a == A_ID)  m[i].q = ID_V;
      else if (m[i].a == A_SCR) m[i].q = m[i].scratch;
      else if (m[i].a == A_CYC) m[i].q = cnt_at(i, e - 1);
      else                      m[i].q = 32'd0;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e = 0;
      for (int i = 0; i < N; i++) begin
        m[i].commit_e = -1;
        m[i].free_e   = 0;
        m[i].a        = '0;
        m[i].d        = '0;
        m[i].w        = 1'b0;
        m[i].q        = '0;
        m[i].q_known  = 1'b1;
        m[i].scratch  = '0;
        m[i].cnt_base = '0;
        m[i].cnt_edge = 0;
      end
    end else begin
      e++;
      for (int i = 0; i < N; i++) begin
        if (e == m[i].commit_e) model_commit(i);
        if (e >= m[i].free_e && start[i]) begin
          m[i].a        = addr[i];
          m[i].d        = wdata[i];
          m[i].w        = we[i];
          m[i].commit_e = e + 1 + wait_of(i);
          m[i].free_e   = e + 3 + wait_of(i);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      check($sformatf("done%0d@%0d", i, e), 32'(done[i]), 32'(m[i].commit_e == e));
      if (m[i].q_known) check($sformatf("q%0d@%0d", i, e), q[i], m[i].q);
    end
  end

  // One request: start raised in cycle 0; lat is the cycle index where done is seen.
  task automatic txn(input int i, input logic [26:0] a, input logic [31:0] d, input logic w,
                     input bit hold, input bit drop, input bit scramble, output int lat);
    @(posedge clk); #1;
    addr[i]  = a;
    wdata[i] = d;
    we[i]    = w;
    start[i] = 1'b1;
    @(posedge clk); #1;
    if (scramble) begin
      addr[i]  = 27'($urandom);
      wdata[i] = $urandom;
      we[i]    = 1'($urandom);
    end
    if (drop) start[i] = 1'b0;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done[i]) begin
        lat = n + 1;
        break;
      end
    end
    if (lat < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout%0d: no bus_done within 40 cycles, expected one", i);
    end
    if (!hold) start[i] = 1'b0;
  endtask

  task automatic rand_run(input int i);
    int          lat;
    int          r;
    bit          hold;
    logic [26:0] a;
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      a = 27'($urandom_range(0, 15));
      else if (r == 4) a = 27'(32'h3F0 + $urandom_range(0, 15));
      else if (r == 5) a = A_ID;
      else if (r == 6) a = A_SCR;
      else if (r == 7) a = A_CYC;
      else if (r == 8) a = 27'(32'h7FFFFF3 + $urandom_range(0, 12));
      else             a = 27'($urandom_range(32'h400, 32'h7FFFFEF));
      hold = (t < 59) && ($urandom_range(0, 2) == 0);
      txn(i, a, $urandom, 1'($urandom), hold, $urandom_range(0, 3) == 0, 1'($urandom), lat);
      if (!hold) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      addr[i] = '0; wdata[i] = '0; we[i] = 1'b0; start[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_q0", q[0], 32'd0);
    check("rst_done0", 32'(done[0]), 32'd0);

    // WAIT=0 write then read
    txn(0, 27'd5, 32'hDEADBEEF, 1'b1, 0, 0, 0, lat);
    check("wr_lat", lat, 2);
    check("q_after_wr", q[0], 32'd0);
    txn(0, 27'd5, 32'd0, 1'b0, 0, 0, 1, lat);
    check("rd_lat", lat, 2);
    check("rd_q", q[0], 32'hDEADBEEF);

    // COPY with start held across read -> write -> read
    txn(0, 27'd5, 32'd0, 1'b0, 1, 0, 0, lat);
    check("copy_rd", q[0], 32'hDEADBEEF);
    txn(0, 27'd6, q[0], 1'b1, 1, 0, 0, lat);
    check("copy_wr_lat", lat, 2);
    txn(0, 27'd6, 32'd0, 1'b0, 0, 0, 0, lat);
    check("copy_q", q[0], 32'hDEADBEEF);

    // CYCLES wrap: FFFFFFFE loaded, five edges later the read samples 3
    txn(0, A_CYC, 32'hFFFFFFFE, 1'b1, 0, 0, 0, lat);
    repeat (3) @(posedge clk);
    txn(0, A_CYC, 32'd0, 1'b0, 0, 0, 0, lat);
    check("cycles_wrap", q[0], 32'h00000003);
    txn(0, 27'h0400000, 32'd0, 1'b0, 0, 0, 0, lat);
    check("unmapped_lat", lat, 2);
    check("unmapped_q", q[0], 32'd0);

    // WAIT=3 ID read, write to ID ignored
    txn(2, A_ID, 32'd0, 1'b0, 0, 0, 0, lat);
    check("id_lat", lat, 5);
    check("id_q", q[2], ID_V);
    @(negedge clk);
    check("id_done_width", 32'(done[2]), 32'd0);
    txn(2, A_ID, 32'h1, 1'b1, 0, 0, 0, lat);
    txn(2, A_ID, 32'd0, 1'b0, 0, 0, 0, lat);
    check("id_ro", q[2], ID_V);

    // WAIT=2 start dropped mid-ACCESS
    txn(1, 27'd9, 32'h00000055, 1'b1, 0, 1, 0, lat);
    check("drop_lat", lat, 4);
    txn(1, 27'd9, 32'd0, 1'b0, 0, 0, 0, lat);
    check("drop_next_lat", lat, 4);
    check("drop_next_q", q[1], 32'h00000055);

    // Reset during DONE drops bus_done at once
    #1 reset = 1'b1;
    #1;
    check("rst_done_pulse", 32'(done[1]), 32'd0);
    check("rst_done_q", q[1], 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Reset mid-ACCESS of a SCRATCH write
    txn(2, A_SCR, 32'h12345678, 1'b1, 0, 0, 0, lat);
    txn(2, A_ID, 32'd0, 1'b0, 0, 0, 0, lat);
    @(posedge clk); #1;
    addr[2] = A_SCR; wdata[2] = 32'hAAAAAAAA; we[2] = 1'b1; start[2] = 1'b1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst_acc_q", q[2], 32'd0);
    check("rst_acc_done", 32'(done[2]), 32'd0);
    start[2] = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    txn(2, A_SCR, 32'd0, 1'b0, 0, 0, 0, lat);
    check("scratch_after_rst", q[2], 32'd0);

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation still running at 500000 ns, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
